stage_f: RTL

Fetch stage of the combined ARM/RISC-V pipeline. It owns the fetch PC, drives a single-outstanding request/response port to instruction memory, and delivers the instruction word to the decode stage on `RDD`, aligned with decode's own PC registers. It also generates `PCF`/`PCPlus4F` and applies redirects from execute and writeback. When no instruction is available it inserts NOP bubbles into decode.

---
 rtl/combi_pkg.sv | 14 +
 rtl/fetch_ctrl.sv | 96 +++++++++
 rtl/stage_f.sv | 89 ++++++++
 3 files changed

// File: rtl/combi_pkg.sv
// Shared types and constants for the combined ARM/RISC-V pipeline.
// The fetch FSM state encoding and the per-ISA NOP words live here.
package combi_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,   // request pending toward instruction memory
      WAIT = 2'd1,   // granted, response outstanding
      HOLD = 2'd2    // response buffered while fetch is stalled
   } fetch_state_e;

   localparam logic [31:0] NOP_ARM = 32'hE1A0_0000;  // MOV r0,r0
   localparam logic [31:0] NOP_RV  = 32'h0000_0013;  // ADDI x0,x0,0

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch request controller: single-outstanding imem handshake, response
// drop after redirect, and a one-word buffer for responses that arrive
// while fetch is stalled.
module fetch_ctrl
   import combi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        redir,
   input  logic [31:0] pcf,
   input  logic [31:0] pcf_plus4,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        avail,
   output logic        advance,
   output logic [31:0] instr_now
);

   fetch_state_e state, state_nx;
   logic         drop, drop_nx;
   logic [31:0]  buf_q, buf_nx;

   // state, drop flag and hold buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= REQ;
         drop  <= 1'b0;
         buf_q <= 32'h0;
      end else begin
         state <= state_nx;
         drop  <= drop_nx;
         buf_q <= buf_nx;
      end
   end

   // next state: a redirect discards whatever is in flight or buffered;
   // a response still outstanding at redirect is marked to be dropped
   always_comb begin
      state_nx = state;
      drop_nx  = drop;
      buf_nx   = buf_q;
      case (state)
         REQ: begin
            // a grant in the redirect cycle carries the stale PC
            if (imem_gnt) begin
               state_nx = WAIT;
               drop_nx  = redir;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               drop_nx = 1'b0;
               if (drop || redir) begin
                  state_nx = REQ;
               end else if (StallF) begin
                  buf_nx   = imem_rdata;
                  state_nx = HOLD;
               end else begin
                  state_nx = imem_gnt ? WAIT : REQ;
               end
            end else if (redir) begin
               drop_nx = 1'b1;
            end
         end
         HOLD: begin
            if (redir)
               state_nx = REQ;
            else if (!StallF)
               state_nx = imem_gnt ? WAIT : REQ;
         end
         default: state_nx = REQ;
      endcase
   end

   // outputs: availability, advance, and request with back-to-back issue
   always_comb begin
      avail     = ((state == WAIT) && imem_rvalid && !drop) || (state == HOLD);
      advance   = avail && !StallF && !redir;
      instr_now = (state == HOLD) ? buf_q : imem_rdata;
      imem_req  = 1'b0;
      imem_addr = pcf;
      if (state == REQ) begin
         imem_req  = 1'b1;
         imem_addr = pcf;
      end else if (advance) begin
         // next word is requested in the same cycle the current one retires
         imem_req  = 1'b1;
         imem_addr = pcf_plus4;
      end
   end

endmodule

// File: rtl/stage_f.sv
// Fetch stage: fetch PC register, redirect mux, and the F->D instruction
// register RDD. Memory handshake lives in fetch_ctrl.
// Build option STAGE_F_ARM_EN: enables the writeback (PCSrcW/ResultW)
// redirect and ARM NOP selection; undefined gives a RISC-V-only fetch.
module stage_f
   import combi_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arm,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        PCSrcW,
   input  logic [31:0] ResultW,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic [31:0] RDD,
   output logic        FetchBusyF
);

   logic        redir;
   logic [31:0] target;
   logic [31:0] nop;
   logic        avail;
   logic        advance;
   logic [31:0] instr_now;

`ifdef STAGE_F_ARM_EN
   // writeback holds the older instruction, so it wins over execute
   assign redir  = PCSrcW | PCSrcE;
   assign target = PCSrcW ? ResultW : PCTargetE;
   assign nop    = arm ? NOP_ARM : NOP_RV;
`else
   logic unused_arm_path;
   assign unused_arm_path = ^{arm, PCSrcW, ResultW};
   assign redir  = PCSrcE;
   assign target = PCTargetE;
   assign nop    = NOP_RV;
`endif

   assign PCPlus4F   = PCF + 32'd4;
   assign FetchBusyF = !avail;

   fetch_ctrl u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .StallF      (StallF),
      .redir       (redir),
      .pcf         (PCF),
      .pcf_plus4   (PCPlus4F),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .avail       (avail),
      .advance     (advance),
      .instr_now   (instr_now)
   );

   // fetch PC: redirect overrides a stall; otherwise step on each retire
   always_ff @(posedge clk) begin
      if (rst)
         PCF <= RESET_PC;
      else if (redir)
         PCF <= target;
      else if (advance)
         PCF <= PCPlus4F;
   end

   // F->D instruction register: bubble when nothing valid or redirecting
   always_ff @(posedge clk) begin
      if (rst || FlushD)
         RDD <= nop;
      else if (!StallD)
         RDD <= (avail && !redir) ? instr_now : nop;
   end

endmodule
